// File: rtl/bus_master_arbiter_if.sv
// rtl/bus_master_arbiter_if.sv - request/grant bus between external masters and the bus arbiter
interface bus_master_arbiter_if #(
   parameter int NREQ = 2
);
   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0] req;
   logic            boundary;
   logic [NREQ-1:0] gnt;
   logic            ctrlen;
   logic            busy;
   logic [IDXW-1:0] owner;

   modport slave (
      input  req,
      input  boundary,
      output gnt,
      output ctrlen,
      output busy,
      output owner
   );

   modport master (
      output req,
      output boundary,
      input  gnt,
      input  ctrlen,
      input  busy,
      input  owner
   );
endinterface

// File: rtl/bus_master_arbiter.sv
// rtl/bus_master_arbiter.sv - CPU/external-master bus arbiter with turnaround cycles (optional tenure limit: ARB_HOLD_LIMIT_EN)
module bus_master_arbiter #(
   parameter int NREQ     = 2,
   parameter int MAX_HOLD = 64
) (
   input  logic                clk,
   input  logic                rstn,
   bus_master_arbiter_if.slave bus
);
   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

   if (NREQ < 1 || NREQ > 8 || MAX_HOLD < 1) begin : g_bad_param
      $error("bus_master_arbiter: NREQ must be 1..8 and MAX_HOLD must be >= 1");
   end

   typedef enum logic [1:0] {
      CPU      = 2'd0,
      TURN_ON  = 2'd1,
      GRANT    = 2'd2,
      TURN_OFF = 2'd3
   } state_t;

   state_t          state;
   logic [NREQ-1:0] gnt_q;
   logic            ctrlen_q;
   logic            busy_q;
   logic [IDXW-1:0] owner_q;
   logic [IDXW-1:0] rr_q;

   logic [NREQ-1:0] elig;
   logic            win_found;
   logic [IDXW-1:0] win_idx;
   logic [IDXW-1:0] cand;
   logic            owner_req;

   // (base + ofs) mod NREQ; both operands are already below NREQ
   function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] base, input int ofs);
      int sum;
      sum = int'(base) + ofs;
      if (sum >= NREQ) sum = sum - NREQ;
      return sum[IDXW-1:0];
   endfunction

   function automatic logic [NREQ-1:0] one_hot(input logic [IDXW-1:0] idx);
      logic [NREQ-1:0] v;
      v = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (int'(idx) == i) v[i] = 1'b1;
      end
      return v;
   endfunction

`ifdef ARB_HOLD_LIMIT_EN
   localparam int HCW = $clog2(MAX_HOLD + 1);

   logic [NREQ-1:0] lockout;
   logic [HCW-1:0]  hold_cnt;
   logic [HCW-1:0]  hold_nxt;

   // a master that was force-released stays ineligible until it lets go of req
   assign elig     = bus.req & ~lockout;
   assign hold_nxt = hold_cnt + 1'b1;
`else
   assign elig     = bus.req;
`endif

   assign owner_req = bus.req[owner_q];

   // round-robin scan starting at rr; first eligible requester wins
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = wrap_add(rr_q, i);
         if (!win_found && elig[cand] == 1'b1) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // ownership FSM; every output is a register updated here
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= CPU;
         gnt_q    <= '0;
         ctrlen_q <= 1'b0;
         busy_q   <= 1'b0;
         owner_q  <= '0;
         rr_q     <= '0;
`ifdef ARB_HOLD_LIMIT_EN
         lockout  <= '0;
         hold_cnt <= '0;
`endif
      end else begin
`ifdef ARB_HOLD_LIMIT_EN
         for (int i = 0; i < NREQ; i++) begin
            if (bus.req[i] == 1'b0) lockout[i] <= 1'b0;
         end
`endif
         case (state)
            CPU: begin
               // only an explicit 1 on boundary moves us; X keeps the CPU in charge
               if (bus.boundary == 1'b1 && win_found == 1'b1) begin
                  owner_q  <= win_idx;
                  ctrlen_q <= 1'b1;
                  busy_q   <= 1'b1;
                  state    <= TURN_ON;
               end
            end
            TURN_ON: begin
               if (owner_req == 1'b1) begin
                  gnt_q <= one_hot(owner_q);
                  state <= GRANT;
`ifdef ARB_HOLD_LIMIT_EN
                  hold_cnt <= '0;
`endif
               end else begin
                  state <= TURN_OFF;
               end
            end
            GRANT: begin
               if (owner_req == 1'b0) begin
                  gnt_q <= '0;
                  rr_q  <= wrap_add(owner_q, 1);
                  state <= TURN_OFF;
               end
`ifdef ARB_HOLD_LIMIT_EN
               else if (hold_nxt == HCW'(MAX_HOLD)) begin
                  gnt_q            <= '0;
                  rr_q             <= wrap_add(owner_q, 1);
                  lockout[owner_q] <= 1'b1;
                  state            <= TURN_OFF;
               end else begin
                  hold_cnt <= hold_nxt;
               end
`endif
            end
            TURN_OFF: begin
               ctrlen_q <= 1'b0;
               busy_q   <= 1'b0;
               state    <= CPU;
            end
            default: begin
               gnt_q    <= '0;
               ctrlen_q <= 1'b0;
               busy_q   <= 1'b0;
               state    <= CPU;
            end
         endcase
      end
   end

   assign bus.gnt    = gnt_q;
   assign bus.ctrlen = ctrlen_q;
   assign bus.busy   = busy_q;
   assign bus.owner  = owner_q;
endmodule

// File: tb/tb_bus_master_arbiter.sv
// tb/tb_bus_master_arbiter.sv - scoreboard bench for bus_master_arbiter
module tb_bus_master_arbiter;
   localparam int NREQ     = 2;
   localparam int MAX_HOLD = 4;

   typedef struct packed {
      logic [NREQ-1:0] gnt;
      logic            ctrlen;
      logic            busy;
      logic            owner;
   } exp_t;

   logic clk = 1'b0;
   logic rstn;
   int   tests_run    = 0;
   int   tests_failed = 0;
   exp_t exp_q[$];

   bus_master_arbiter_if #(.NREQ(NREQ)) bus ();

   bus_master_arbiter #(
      .NREQ     (NREQ),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      tests_run++;
      if (got !== want) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, want);
      end
   endtask

   // drive one cycle of inputs, queue the expected outputs, compare after the edge
   task automatic step(input string tag, input logic [NREQ-1:0] r, input logic b,
                       input logic [NREQ-1:0] eg, input logic ec, input logic eb, input logic eo);
      exp_t e;
      exp_t want;
      bus.req      = r;
      bus.boundary = b;
      e.gnt    = eg;
      e.ctrlen = ec;
      e.busy   = eb;
      e.owner  = eo;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      want = exp_q.pop_front();
      check_eq({tag, ".gnt"},    32'(bus.gnt),    32'(want.gnt));
      check_eq({tag, ".ctrlen"}, 32'(bus.ctrlen), 32'(want.ctrlen));
      check_eq({tag, ".busy"},   32'(bus.busy),   32'(want.busy));
      check_eq({tag, ".owner"},  32'(bus.owner),  32'(want.owner));
   endtask

   // the grant must never be visible while the control word is still driven
   always @(negedge clk) begin
      check_eq("no_overlap", 32'((|bus.gnt) & ~bus.ctrlen), 32'd0);
   end

   initial begin
      logic [NREQ-1:0] oh;
      logic            o;

      bus.req      = '0;
      bus.boundary = 1'b0;
      rstn         = 1'b0;
      #2;
      check_eq("rst.gnt",    32'(bus.gnt),    32'd0);
      check_eq("rst.ctrlen", 32'(bus.ctrlen), 32'd0);
      check_eq("rst.busy",   32'(bus.busy),   32'd0);
      check_eq("rst.owner",  32'(bus.owner),  32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rstn = 1'b1;

      repeat (5) step("defer", 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      step("defer_bnd",  2'b01, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0);
      step("defer_gnt",  2'b01, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0);
      step("defer_hold", 2'b01, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0);

      rstn = 1'b0;
      #1;
      check_eq("midrst.gnt",    32'(bus.gnt),    32'd0);
      check_eq("midrst.ctrlen", 32'(bus.ctrlen), 32'd0);
      check_eq("midrst.busy",   32'(bus.busy),   32'd0);
      check_eq("midrst.owner",  32'(bus.owner),  32'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      step("post_rst", 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

      step("rel_bnd",  2'b01, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0);
      step("rel_gnt",  2'b01, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0);
      step("rel_drop", 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
      step("rel_cpu",  2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

      step("bnd_noreq", 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);

      step("wd_bnd",  2'b10, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1);
      step("wd_off",  2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1);
      step("wd_cpu",  2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);

      repeat (3) step("xreq", 'x, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
      step("xreq_clr", 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);

      rstn = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      for (int t = 0; t < 4; t++) begin
         o  = t[0];
         oh = o ? 2'b10 : 2'b01;
         step("rr_bnd", 2'b11, 1'b1, 2'b00, 1'b1, 1'b1, o);
         repeat (3) step("rr_gnt", 2'b11, 1'b0, oh, 1'b1, 1'b1, o);
         step("rr_drop", 2'b11 & ~oh, 1'b0, 2'b00, 1'b1, 1'b1, o);
         step("rr_cpu",  2'b11, 1'b0, 2'b00, 1'b0, 1'b0, o);
      end
      step("rr_idle", 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);

`ifdef ARB_HOLD_LIMIT_EN
      step("hl_bnd", 2'b01, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0);
      repeat (4) step("hl_gnt", 2'b01, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0);
      step("hl_force", 2'b01, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
      step("hl_cpu",   2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      repeat (3) step("hl_locked", 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
      step("hl_unlock", 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      step("hl_rebnd",  2'b01, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0);
      step("hl_regnt",  2'b01, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0);
      step("hl_drop",   2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
      step("hl_end",    2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
`else
      step("long_bnd", 2'b01, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0);
      repeat (8) step("long_gnt", 2'b01, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0);
      step("long_drop", 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
      step("long_end",  2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/bus_master_arbiter.md
Name: bus_master_arbiter

Overview:
- Shares the CPU control/data bus between the microcode control logic (default owner) and NREQ external masters (front-panel loader, debugger, DMA).
- Drives the control unit's active-high control-output disable (ctrlen), which tristates the control word.
- Grants an external master only at an instruction boundary, with one dead turnaround cycle on each handover so bus drivers never overlap.

Parameters:
- NREQ, 2, number of external requesters (1..8).
- MAX_HOLD, 64, maximum consecutive GRANT cycles per tenure; used only when ARB_HOLD_LIMIT_EN is defined. Must be >= 1.
- IDXW, derived: max(1, clog2(NREQ)); not user-overridable.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rstn  in  1  asynchronous active-low reset.
- req  in  NREQ  level request per external master; held until done.
- boundary  in  1  high for the cycle in which the step counter reloads (instruction boundary).
- gnt  out  NREQ  one-hot grant; at most one bit high.
- ctrlen  out  1  high disables the control unit's control word output.
- busy  out  1  high in any state other than CPU.
- owner  out  IDXW  index of the current or most recent external owner.

Behaviour:
- Reset is asynchronous and takes effect immediately. Reset values:
  - state=CPU, gnt=0, ctrlen=0, busy=0, owner=0.
  - Round-robin pointer rr=0, hold counter=0, lockout mask=0.
- All outputs are registered. No combinational path from inputs to outputs.
- States: CPU, TURN_ON, GRANT, TURN_OFF.
- CPU:
  - Leave CPU only when boundary=1 AND (req & ~lockout)!=0 at the same posedge.
  - Winner = first eligible requester scanning rr, rr+1, … mod NREQ.
  - At that edge: owner=winner, ctrlen=1, busy=1, next state TURN_ON.
  - req without boundary, or boundary without req: stay in CPU.
- TURN_ON (exactly 1 cycle):
  - ctrlen=1, gnt=0.
  - If req[owner]=1 at the edge: gnt[owner]=1, next state GRANT.
  - If req[owner]=0 at the edge: next state TURN_OFF; gnt is never asserted.
- GRANT:
  - gnt[owner]=1 while req[owner]=1.
  - When req[owner]=0 at an edge: gnt=0, rr=(owner+1) mod NREQ, next state TURN_OFF.
  - Requests from other masters are ignored in GRANT.
- TURN_OFF (exactly 1 cycle):
  - ctrlen=1, gnt=0.
  - Next edge: ctrlen=0, busy=0, state CPU.
  - Bus always returns to the CPU between external tenures, so the CPU is never starved.
  - A new grant needs the next boundary, earliest the cycle after returning to CPU.
- Latency:
  - req & boundary sampled at edge N: ctrlen=1 after N, gnt=1 after N+1.
  - req dropped at edge M: gnt=0 after M, ctrlen=0 after M+1.
- Counters:
  - rr wraps mod NREQ; with NREQ=1, rr stays 0.
  - owner keeps its value in CPU; it shows the last owner.
- Reset mid-tenure: gnt and ctrlen drop asynchronously; the CPU owns the bus on release.
- Undefined (X) req bits must not corrupt state; the bench checks this with X-injection and expects a CPU hold.

Optional Feature:
- Macro: ARB_HOLD_LIMIT_EN.
- Defined:
  - Hold counter clears on entry to GRANT and increments each GRANT cycle.
  - On the edge where the counter reaches MAX_HOLD, the arbiter force-releases: gnt=0, rr advance, state TURN_OFF, lockout[owner]=1.
  - A lockout bit clears when that req is seen low. A locked-out master is ineligible until then.
- Not defined: no counter and no lockout logic; tenure is unlimited; MAX_HOLD is ignored.

Test Plan:
- Reset mid-GRANT (NREQ=2, req=01): rstn low -> gnt=00, ctrlen=0, busy=0 immediately; after release, state CPU, owner=0.
- Deferred grant: req=01 held with boundary low for 5 cycles -> gnt=00, ctrlen=0. Boundary pulse at edge N -> ctrlen=1 after N, gnt=01 after N+1.
- Release: in GRANT, req=00 at edge M -> gnt=00 after M, ctrlen=0 after M+1, busy=0. Never gnt=1 while ctrlen=0.
- Round robin: req=11 held, boundary pulse each CPU visit with each master dropping req after 3 cycles -> owner sequence 0,1,0,1. A CPU state of at least 1 cycle separates tenures.
- Withdrawal in TURN_ON: req=10 with boundary, req drops to 00 during TURN_ON -> gnt stays 00, TURN_OFF, then CPU after 2 edges total.
- ARB_HOLD_LIMIT_EN, MAX_HOLD=4: req=01 held continuously -> gnt=01 for exactly 4 cycles, then 00. Further boundaries do not grant master 0 until req is seen low and re-raised.
